// File: rtl/sonar_mmio_pkg.sv
// Shared definitions for the sonar MMIO peripheral: FSM encoding, register
// offsets and STATUS bit layout.
package sonar_mmio_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] ST_TRIG      = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_RISE = 2'd2;
  localparam logic [STATE_W-1:0] ST_MEASURE   = 2'd3;

  localparam logic [11:0] OFS_CTRL   = 12'd0;
  localparam logic [11:0] OFS_RESULT = 12'd1;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_VALID   = 1;
  localparam int unsigned STAT_TIMEOUT = 2;

  typedef struct packed {
    logic timeout;
    logic result_valid;
    logic busy;
  } status_t;

  // Place the status flags at their architectural bit positions.
  function automatic logic [31:0] status_word(input status_t s);
    logic [31:0] w;
    w               = '0;
    w[STAT_BUSY]    = s.busy;
    w[STAT_VALID]   = s.result_valid;
    w[STAT_TIMEOUT] = s.timeout;
    return w;
  endfunction

endpackage

// File: rtl/sonar_mmio_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with registered rise/fall
// pulses aligned to the first cycle the synchronized level changes.
module sync_edge (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
      rise  <= meta & ~level;
      fall  <= ~meta & level;
    end
  end

endmodule

// File: rtl/sonar_mmio.sv
// Memory-mapped ultrasonic ranger: a CTRL/STATUS word starts a trigger pulse,
// the echo pulse width is measured in clock cycles and exposed as RESULT.
module sonar_mmio
  import sonar_mmio_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR      = 12'hF00,
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_io,
  output logic        io_hit,
  output logic        trig,
  input  logic        echo
);

  localparam int unsigned MAX_CNT = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [11:0]      CTRL_ADDR   = 12'(BASE_ADDR + OFS_CTRL);
  localparam logic [11:0]      RESULT_ADDR = 12'(BASE_ADDR + OFS_RESULT);
  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIDTH_MAX   = CNT_W'(TIMEOUT_CYCLES);

  logic [STATE_W-1:0] state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               trig_d;
  logic [31:0]        result, result_d;
  logic               result_valid, valid_d;
  logic               timeout, timeout_d;

  logic               echo_level, echo_rise, echo_fall;
  logic [11:0]        addr_c;
  logic               start_c;
  logic               rd_hit_c;
  logic [31:0]        rd_data_c;
  status_t            status_c;
  logic               unused_bits;

  assign unused_bits = ^{address_dmem[31:12], data[31:1]};

  sync_edge u_sync_edge (
    .clock  (clock),
    .resetn (resetn),
    .din    (echo),
    .level  (echo_level),
    .rise   (echo_rise),
    .fall   (echo_fall)
  );

  assign addr_c  = address_dmem[11:0];
  assign start_c = wren && (addr_c == CTRL_ADDR) && data[0];

  // One counter serves as trigger timer, rise timeout and echo width.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    trig_d    = 1'b0;
    result_d  = result;
    valid_d   = result_valid;
    timeout_d = timeout;
    case (state)
      ST_IDLE: begin
        if (start_c) begin
          state_d   = ST_TRIG;
          cnt_d     = CNT_W'(1);
          trig_d    = 1'b1;
          valid_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt + CNT_W'(1);
          trig_d = 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt == WAIT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          result_d  = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          state_d  = ST_IDLE;
          result_d = 32'(cnt);
          valid_d  = 1'b1;
        end else if (cnt == WIDTH_MAX) begin
          // Saturate instead of wrapping on an over-long echo.
          state_d   = ST_IDLE;
          result_d  = 32'(TIMEOUT_CYCLES);
          valid_d   = 1'b1;
          timeout_d = 1'b1;
        end else if (echo_level) begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read decode; registered below for RAM-like one-cycle latency.
  always_comb begin
    status_c.busy         = (state != ST_IDLE);
    status_c.result_valid = result_valid;
    status_c.timeout      = timeout;
    rd_hit_c              = 1'b0;
    rd_data_c             = '0;
    if (!wren) begin
      if (addr_c == CTRL_ADDR) begin
        rd_hit_c  = 1'b1;
        rd_data_c = status_word(status_c);
      end else if (addr_c == RESULT_ADDR) begin
        rd_hit_c  = 1'b1;
        rd_data_c = result;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      trig         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      io_hit       <= 1'b0;
      q_io         <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      trig         <= trig_d;
      result       <= result_d;
      result_valid <= valid_d;
      timeout      <= timeout_d;
      io_hit       <= rd_hit_c;
      q_io         <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_sonar_mmio.sv
// Self-checking bench for sonar_mmio with short trigger/timeout parameters.
module tb_sonar_mmio;

  localparam int unsigned TRIG = 10;
  localparam int unsigned TO   = 200;
  localparam logic [31:0] CTRL = 32'h0000_0F00;
  localparam logic [31:0] RES  = 32'h0000_0F01;

  logic        clock = 1'b0;
  logic        resetn;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_io;
  logic        io_hit;
  logic        trig;
  logic        echo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] q;
    int unsigned tol;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        hit;
    logic [31:0] q;
    string       name;
  } vec_t;

  exp_t sbq[$];
  vec_t vq[$];

  sonar_mmio #(
    .BASE_ADDR      (12'hF00),
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .q_io         (q_io),
    .io_hit       (io_hit),
    .trig         (trig),
    .echo         (echo)
  );

  always #5 clock = ~clock;

  // Trigger pulse monitor: length of the most recent high run.
  int run_len  = 0;
  int last_len = 0;
  int falls    = 0;
  always @(negedge clock) begin
    if (trig) run_len++;
    else if (run_len > 0) begin
      last_len = run_len;
      falls++;
      run_len = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int unsigned tol);
    logic [31:0] diff;
    total++;
    diff = (act > exp) ? act - exp : exp - act;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // Drive one bus cycle, queue its expected read-back, compare one cycle later.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input string nm, input logic eh, input logic [31:0] eq, input int unsigned tol);
    exp_t e;
    @(negedge clock);
    wren = w; address_dmem = a; data = d;
    e.name = nm; e.hit = eh; e.q = eq; e.tol = tol;
    sbq.push_back(e);
    @(negedge clock);
    wren = 1'b0; address_dmem = 32'h0; data = 32'h0;
    e = sbq.pop_front();
    check({e.name, "_hit"}, 32'(io_hit), 32'(e.hit), 0);
    check({e.name, "_q"}, q_io, e.q, e.tol);
  endtask

  task automatic rd(input logic [31:0] a, input string nm, input logic eh, input logic [31:0] eq, input int unsigned tol);
    bus(1'b0, a, 32'h0, nm, eh, eq, tol);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    bus(1'b1, a, d, nm, 1'b0, 32'h0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_trig_fall(input string nm);
    int f0;
    bit seen;
    f0   = falls;
    seen = 1'b0;
    for (int i = 0; i < 4 * TRIG + 20; i++) begin
      @(negedge clock);
      #1;
      if (falls != f0) begin
        seen = 1'b1;
        break;
      end
    end
    check({nm, "_trig_fell"}, 32'(seen), 32'd1, 0);
    check({nm, "_trig_len"}, 32'(last_len), 32'(TRIG), 0);
  endtask

  task automatic add_vec(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic eh, input logic [31:0] eq, input string nm);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.hit = eh; v.q = eq; v.name = nm;
    vq.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f_keep;
    resetn = 1'b0; wren = 1'b0; address_dmem = 32'h0; data = 32'h0; echo = 1'b0;

    add_vec(1'b0, CTRL,          32'h0, 1'b1, 32'h0, "t_rd_status");
    add_vec(1'b0, RES,           32'h0, 1'b1, 32'h0, "t_rd_result");
    add_vec(1'b0, 32'h0000_0123, 32'h0, 1'b0, 32'h0, "t_rd_unmapped");
    add_vec(1'b0, 32'h0000_0F02, 32'h0, 1'b0, 32'h0, "t_rd_f02");
    add_vec(1'b0, 32'h0000_0EFF, 32'h0, 1'b0, 32'h0, "t_rd_eff");
    add_vec(1'b1, RES,           32'h1, 1'b0, 32'h0, "t_wr_result");
    add_vec(1'b0, CTRL,          32'h0, 1'b1, 32'h0, "t_after_wr_result");
    add_vec(1'b1, CTRL,          32'h2, 1'b0, 32'h0, "t_wr_bit0_clear");
    add_vec(1'b0, CTRL,          32'h0, 1'b1, 32'h0, "t_after_wr_bit0");
    add_vec(1'b0, 32'h1234_5F00, 32'h0, 1'b1, 32'h0, "t_rd_upper_bits");

    repeat (3) @(negedge clock);
    check("rst_trig", 32'(trig), 32'd0, 0);
    check("rst_hit", 32'(io_hit), 32'd0, 0);
    check("rst_q", q_io, 32'd0, 0);
    resetn = 1'b1;

    foreach (vq[i]) bus(vq[i].w, vq[i].a, vq[i].d, vq[i].name, vq[i].hit, vq[i].q, 0);

    // Normal 50-cycle echo
    wr(CTRL, 32'h1, "s1_start");
    rd(CTRL, "s1_busy", 1'b1, 32'h1, 0);
    wait_trig_fall("s1");
    idle(20); echo = 1'b1; idle(50); echo = 1'b0; idle(8);
    rd(CTRL, "s1_status", 1'b1, 32'h2, 0);
    rd(RES, "s1_result", 1'b1, 32'd50, 1);

    // No echo: rise timeout
    wr(CTRL, 32'h1, "s2_start");
    rd(CTRL, "s2_flags_cleared", 1'b1, 32'h1, 0);
    wait_trig_fall("s2");
    idle(150);
    rd(CTRL, "s2_still_waiting", 1'b1, 32'h1, 0);
    idle(60);
    rd(CTRL, "s2_status", 1'b1, 32'h4, 0);
    rd(RES, "s2_result", 1'b1, 32'd0, 0);

    // Over-long echo saturates at the timeout width
    wr(CTRL, 32'h1, "s3_start");
    wait_trig_fall("s3");
    idle(3); echo = 1'b1; idle(300);
    rd(CTRL, "s3_status", 1'b1, 32'h6, 0);
    rd(RES, "s3_result", 1'b1, 32'(TO), 0);
    idle(196); echo = 1'b0; idle(8);
    rd(CTRL, "s3_status_after", 1'b1, 32'h6, 0);
    rd(RES, "s3_result_after", 1'b1, 32'(TO), 0);

    // Restart write during MEASURE is ignored
    wr(CTRL, 32'h1, "s4_start");
    wait_trig_fall("s4");
    f_keep = falls;
    idle(5); echo = 1'b1; idle(20);
    wr(CTRL, 32'h1, "s4_restart");
    rd(CTRL, "s4_busy", 1'b1, 32'h1, 0);
    idle(36); echo = 1'b0; idle(8);
    rd(CTRL, "s4_status", 1'b1, 32'h2, 0);
    rd(RES, "s4_result", 1'b1, 32'd60, 1);
    check("s4_no_new_trig", 32'(falls), 32'(f_keep), 0);

    // Echo already high when the trigger ends
    wr(CTRL, 32'h1, "s5_start");
    idle(2); echo = 1'b1;
    wait_trig_fall("s5");
    idle(3); echo = 1'b0; idle(5); echo = 1'b1; idle(30); echo = 1'b0; idle(8);
    rd(CTRL, "s5_status", 1'b1, 32'h2, 0);
    rd(RES, "s5_result", 1'b1, 32'd30, 1);

    // Reset pulse during TRIG
    wr(CTRL, 32'h1, "s6_start");
    idle(3);
    check("s6_trig_on", 32'(trig), 32'd1, 0);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("s6_trig_off", 32'(trig), 32'd0, 0);
    check("s6_hit_off", 32'(io_hit), 32'd0, 0);
    idle(20);
    check("s6_trig_stays_low", 32'(run_len), 32'd0, 0);
    rd(CTRL, "s6_status", 1'b1, 32'h0, 0);
    rd(RES, "s6_result", 1'b1, 32'h0, 0);
    rd(32'h0000_0123, "s6_unmapped", 1'b0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sonar_mmio.md
SONAR_MMIO -- requirements
Module: sonar_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 12'hF00: word address of the CTRL/STATUS register; RESULT is at BASE_ADDR+1.
REQ-002 Parameter TRIG_CYCLES, default 1000: trigger pulse width in clock cycles (10 us at 100 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 2500000: maximum wait for echo rise, and maximum echo width.
REQ-004 clock  in  1  single system clock; all logic on its rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 wren  in  1  processor data-memory write enable.
REQ-007 address_dmem  in  32  processor data address; only bits [11:0] are decoded.
REQ-008 data  in  32  processor store data.
REQ-009 q_io  out  32  registered read data for a mapped address.
REQ-010 io_hit  out  1  registered; high in the cycle q_io is valid, so the top level can mux q_io over RAM output.
REQ-011 trig  out  1  drive to the sonar trigger pin.
REQ-012 echo  in  1  asynchronous sonar echo pin.

Function
REQ-013 echo SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signal only.
REQ-014 The FSM SHALL have states IDLE, TRIG, WAIT_RISE, MEASURE.
REQ-015 IDLE->TRIG on a write to BASE_ADDR with data[0]=1; result_valid and timeout SHALL clear in that same edge.
REQ-016 In TRIG, trig=1 for exactly TRIG_CYCLES cycles, then TRIG->WAIT_RISE with trig=0.
REQ-017 WAIT_RISE->MEASURE on the synchronized echo rising edge; width counter loads 1 on that edge.
REQ-018 WAIT_RISE->IDLE with timeout=1 and result=0 after TIMEOUT_CYCLES cycles without a rise.
REQ-019 MEASURE increments width each cycle synced echo stays high; on falling edge, result=width, result_valid=1, ->IDLE.
REQ-020 MEASURE->IDLE with timeout=1, result_valid=1, result=TIMEOUT_CYCLES when the width reaches TIMEOUT_CYCLES; the counter SHALL never wrap.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 A start write while busy SHALL be ignored: no restart, flags unchanged.
REQ-023 Echo high on entry to WAIT_RISE is not a rise; only a subsequent low->high counts.
REQ-024 Reads: when address_dmem[11:0] equals BASE_ADDR or BASE_ADDR+1 and wren=0, io_hit and q_io SHALL assert on the next edge (1-cycle latency, same as RAM).
REQ-025 STATUS read value = {29'b0, timeout, result_valid, busy}; RESULT read value = 32-bit result.
REQ-026 Writes to BASE_ADDR+1, and writes with data[0]=0, SHALL have no effect.
REQ-027 Non-mapped addresses: io_hit=0, q_io=0.

Reset
REQ-028 With resetn=0 at a clock edge: state=IDLE, trig=0, busy=0, result=0, result_valid=0, timeout=0, io_hit=0, q_io=0, and synchronizer flops=0.
REQ-029 Reset mid-measurement SHALL abort immediately; trig SHALL be 0 the cycle after the reset edge.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, register offsets (CTRL=0, RESULT=1) and STATUS bit positions.
REQ-031 The synchronizer plus edge detector SHALL be one sub-module, sync_edge (outputs: level, rise, fall).

Verification (TRIG_CYCLES=10, TIMEOUT_CYCLES=200, BASE_ADDR=12'hF00)
REQ-032 Write 1 to 0xF00, then echo high for 50 cycles starting 20 cycles after trig falls -> trig high for exactly 10 cycles; STATUS=3'b010; RESULT=50 ±1 (synchronizer-quantization tolerance).
REQ-033 Start, then echo held low -> after 200 cycles in WAIT_RISE, STATUS=3'b100 and RESULT=0.
REQ-034 Start, then echo high for 500 cycles -> RESULT=200, STATUS=3'b110, no counter wrap.
REQ-035 Second start write during MEASURE -> ignored; the first result completes unchanged.
REQ-036 Echo already high when trig falls, then low for 5 cycles, then high for 30 cycles -> RESULT=30 ±1.
REQ-037 resetn=0 for one cycle during TRIG -> trig=0 next cycle; STATUS=0; RESULT=0; a read of 0x123 gives io_hit=0.
